// File: rtl/ans_decoder_if.sv
// Handshake bundle for the rANS decoder: init load, LIFO chunk feed, symbol output.
// The master modport is the host side; the slave modport is the decoder.
interface ans_decoder_if #(
    parameter int SYM_WIDTH   = 8,
    parameter int STATE_WIDTH = 16,
    parameter int IDX_W       = 4
);
    logic                   init_vld;
    logic                   init_rdy;
    logic [STATE_WIDTH-1:0] init_state;
    logic [15:0]            init_nsym;
    logic [SYM_WIDTH-1:0]   in_chunk;
    logic                   in_vld;
    logic                   in_rdy;
    logic [IDX_W-1:0]       out_sym;
    logic                   out_last;
    logic                   out_vld;
    logic                   out_rdy;

    modport master (
        output init_vld, init_state, init_nsym, in_chunk, in_vld, out_rdy,
        input  init_rdy, in_rdy, out_sym, out_last, out_vld
    );

    modport slave (
        input  init_vld, init_state, init_nsym, in_chunk, in_vld, out_rdy,
        output init_rdy, in_rdy, out_sym, out_last, out_vld
    );
endinterface

// File: rtl/ans_decoder.sv
// rANS decoder: linear table search (one entry/cycle, first symbol k+1 cycles after init),
// renormalizes from a LIFO chunk feed; all ready/valid outputs decode from state, any stall is legal.
module ans_decoder #(
    parameter int SYM_WIDTH   = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int STATE_WIDTH = 16,
    parameter int NSYM        = 16,
    localparam int IDX_W      = $clog2(NSYM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena_i,
    input  logic [STATE_WIDTH-1:0] total_count_i,
    input  logic                   tbl_we_i,
    input  logic [IDX_W-1:0]       tbl_addr_i,
    input  logic [CNT_WIDTH-1:0]   tbl_count_i,
    input  logic [STATE_WIDTH-1:0] tbl_cum_i,
    ans_decoder_if.slave           bus,
    output logic                   err_o
);
    typedef enum logic [1:0] {IDLE, SEARCH, EMIT, RENORM} state_t;

    state_t                 state_q;
    logic [STATE_WIDTH-1:0] x_q;
    logic [15:0]            n_q;
    logic [IDX_W-1:0]       i_q;
    logic [IDX_W-1:0]       sym_q;
    logic                   last_q;
    logic                   err_q;
    logic [CNT_WIDTH-1:0]   cnt_q [NSYM];
    logic [STATE_WIDTH-1:0] cum_q [NSYM];

    logic [STATE_WIDTH-1:0] rem, quo, cnt_ext, cum_cur, off, x_dec, x_shift;
    logic                   hit, i_end;

    // A zero M can only come from a misconfigured table; keep the divider defined anyway.
    always_comb begin
        rem = '0;
        quo = '0;
        if (total_count_i != '0) begin
            rem = x_q % total_count_i;
            quo = x_q / total_count_i;
        end
        cnt_ext = STATE_WIDTH'(cnt_q[i_q]);
        cum_cur = cum_q[i_q];
        off     = rem - cum_cur;
        hit     = (cnt_ext != '0) && (rem >= cum_cur) && (off < cnt_ext);
        x_dec   = cnt_ext * quo + off;
        x_shift = (x_q << SYM_WIDTH) | STATE_WIDTH'(bus.in_chunk);
    end

    assign i_end = (i_q == IDX_W'(NSYM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            sym_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena_i) begin
            case (state_q)
                IDLE: if (bus.init_vld) begin
                    x_q     <= bus.init_state;
                    n_q     <= (bus.init_nsym == 16'd0) ? 16'd1 : bus.init_nsym;
                    i_q     <= '0;
                    err_q   <= 1'b0;
                    state_q <= SEARCH;
                end
                SEARCH: if (hit) begin
                    x_q     <= x_dec;
                    sym_q   <= i_q;
                    last_q  <= (n_q == 16'd1);
                    state_q <= EMIT;
                end else if (i_end) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    i_q <= i_q + IDX_W'(1);
                end
                EMIT: if (bus.out_rdy) begin
                    n_q <= n_q - 16'd1;
                    i_q <= '0;
                    if (last_q) begin
                        // A clean block unwinds exactly to the encoder's starting state M+1.
                        err_q   <= err_q | (x_q != total_count_i + STATE_WIDTH'(1));
                        state_q <= IDLE;
                    end else if (x_q < total_count_i) begin
                        state_q <= RENORM;
                    end else begin
                        state_q <= SEARCH;
                    end
                end
                RENORM: if (bus.in_vld) begin
                    x_q <= x_shift;
                    if (x_shift >= total_count_i) state_q <= SEARCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NSYM; e++) begin
                cnt_q[e] <= '0;
                cum_q[e] <= '0;
            end
        end else if (ena_i && tbl_we_i && state_q == IDLE) begin
            cnt_q[tbl_addr_i] <= tbl_count_i;
            cum_q[tbl_addr_i] <= tbl_cum_i;
        end
    end

    assign bus.init_rdy = (state_q == IDLE);
    assign bus.in_rdy   = (state_q == RENORM);
    assign bus.out_vld  = (state_q == EMIT);
    assign bus.out_sym  = sym_q;
    assign bus.out_last = last_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_ans_decoder.sv
// Bench for ans_decoder: directed cases plus random tables/blocks produced by a behavioural rANS encoder.
`timescale 1ns/1ps
module tb_ans_decoder;
    localparam int SW = 4, CW = 8, STW = 16, NS = 16, IW = 4, MT = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic [STW-1:0] total_count = STW'(MT);
    logic           tbl_we = 1'b0;
    logic [IW-1:0]  tbl_addr = '0;
    logic [CW-1:0]  tbl_count = '0;
    logic [STW-1:0] tbl_cum = '0;
    logic           err;

    ans_decoder_if #(.SYM_WIDTH(SW), .STATE_WIDTH(STW), .IDX_W(IW)) bus();

    ans_decoder #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .STATE_WIDTH(STW), .NSYM(NS)) dut (
        .clk(clk), .rst_n(rst_n), .ena_i(ena), .total_count_i(total_count),
        .tbl_we_i(tbl_we), .tbl_addr_i(tbl_addr), .tbl_count_i(tbl_count), .tbl_cum_i(tbl_cum),
        .bus(bus), .err_o(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int tcnt [NS];
    int tcum [NS];
    int chunk_stk [$];
    int got_sym [$];
    int got_last [$];
    int first_lat, end_lat, last_acc_lat, timed_out, unstable, junk_taken, rdy_seen;
    logic err_end;

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Reference rANS encoder (L = M, b = 16, starting state M+1); chunks stack up LIFO.
    function automatic int encode(input int seq[$]);
        int x = MT + 1;
        chunk_stk.delete();
        foreach (seq[j]) begin
            int c = tcnt[seq[j]];
            while (x >= c * 16) begin
                chunk_stk.push_back(x % 16);
                x = x / 16;
            end
            x = (x / c) * MT + tcum[seq[j]] + x % c;
        end
        return x;
    endfunction

    task automatic set_case_table();
        for (int e = 0; e < NS; e++) tcnt[e] = 0;
        tcnt[0] = 8; tcnt[1] = 4; tcnt[2] = 2; tcnt[3] = 2;
    endtask

    task automatic load_table();
        int acc = 0;
        for (int e = 0; e < NS; e++) begin
            tcum[e] = acc;
            acc += tcnt[e];
        end
        for (int e = 0; e < NS; e++) begin
            @(negedge clk);
            ena = 1'b1; tbl_we = 1'b1; tbl_addr = IW'(e);
            tbl_count = CW'(tcnt[e]); tbl_cum = STW'(tcum[e]);
        end
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // ena_pct < 0 selects the scripted stall: ena toggles, out_rdy waits 5 valid cycles.
    task automatic run_block(input int st, input int nsym, input int ena_pct, input int rdy_pct, input bit poke);
        int lat, w, hsym, vld_run;
        bit held;
        logic hlast;
        got_sym.delete(); got_last.delete();
        first_lat = -1; end_lat = -1; last_acc_lat = -1; timed_out = 0;
        unstable = 0; junk_taken = 0; rdy_seen = 0; err_end = 1'bx;
        held = 0; vld_run = 0; hsym = 0; hlast = 1'b0;
        @(negedge clk);
        ena = 1'b1; bus.init_state = STW'(st); bus.init_nsym = 16'(nsym);
        bus.init_vld = 1'b1; bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
        w = 0;
        while (!bus.init_rdy && w < 50) begin @(negedge clk); w++; end
        if (!bus.init_rdy) timed_out = 1;
        @(negedge clk);
        bus.init_vld = 1'b0;
        lat = 0;
        while (timed_out == 0) begin
            if (bus.init_rdy) begin end_lat = lat; err_end = err; break; end
            if (lat > 3000) begin timed_out = 1; break; end
            if (bus.in_rdy) rdy_seen++;
            if (held && bus.out_vld && (int'(bus.out_sym) != hsym || bus.out_last !== hlast)) unstable++;
            if (bus.out_vld && first_lat < 0) first_lat = lat;
            vld_run = bus.out_vld ? vld_run + 1 : 0;
            if (ena_pct < 0) begin
                ena = (lat % 2 == 0);
                bus.out_rdy = (vld_run > 5);
            end else begin
                ena = ($urandom_range(0, 99) < ena_pct);
                bus.out_rdy = ($urandom_range(0, 99) < rdy_pct);
            end
            bus.in_vld = 1'b1;
            bus.in_chunk = (chunk_stk.size() > 0) ? SW'(chunk_stk[$]) : SW'($urandom);
            tbl_we = poke && ($urandom_range(0, 2) == 0);
            tbl_addr = IW'($urandom); tbl_count = CW'($urandom); tbl_cum = STW'($urandom);
            if (ena && bus.out_vld && bus.out_rdy) begin
                got_sym.push_back(int'(bus.out_sym));
                got_last.push_back(int'(bus.out_last));
                last_acc_lat = lat; held = 0; vld_run = 0;
            end else begin
                held = bus.out_vld; hsym = int'(bus.out_sym); hlast = bus.out_last;
            end
            if (ena && bus.in_rdy) begin
                if (chunk_stk.size() > 0) void'(chunk_stk.pop_back());
                else junk_taken++;
            end
            @(negedge clk);
            lat++;
        end
        ena = 1'b1; bus.in_vld = 1'b0; bus.out_rdy = 1'b0; tbl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.init_rdy !== 1'b1) begin bad++; $display("FAIL reset_init_rdy: got %b expected 1", bus.init_rdy); end
        total++; if (bus.in_rdy !== 1'b0) begin bad++; $display("FAIL reset_in_rdy: got %b expected 0", bus.in_rdy); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
        total++; if (bus.out_sym !== 4'd0) begin bad++; $display("FAIL reset_out_sym: got %0d expected 0", bus.out_sym); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_zero_table();
        chunk_stk.delete();
        run_block(20, 1, 100, 100, 0);
        total++; if (got_sym.size() != 0 || timed_out != 0) begin bad++; $display("FAIL zero_tbl_no_sym: got %0d symbols timeout=%0d expected 0 and 0", got_sym.size(), timed_out); end
        total++; if (err_end !== 1'b1) begin bad++; $display("FAIL zero_tbl_err: got %b expected 1", err_end); end
        total++; if (end_lat != NS) begin bad++; $display("FAIL zero_tbl_search_cycles: got %0d expected %0d", end_lat, NS); end
        repeat (3) @(negedge clk);
        total++; if (err !== 1'b1 || bus.init_rdy !== 1'b1) begin bad++; $display("FAIL zero_tbl_err_sticky: err=%b init_rdy=%b expected 1 1", err, bus.init_rdy); end
    endtask

    task automatic test_directed();
        set_case_table();
        load_table();
        chunk_stk.delete();
        run_block(145, 2, 100, 100, 0);
        total++; if (got_sym.size() != 2 || timed_out != 0) begin bad++; $display("FAIL c1_count: got %0d symbols timeout=%0d expected 2", got_sym.size(), timed_out); end
        total++; if (qget(got_sym, 0) != 0 || qget(got_sym, 1) != 1) begin bad++; $display("FAIL c1_syms: got %0d,%0d expected 0,1", qget(got_sym, 0), qget(got_sym, 1)); end
        total++; if (qget(got_last, 0) != 0 || qget(got_last, 1) != 1) begin bad++; $display("FAIL c1_last: got %0d,%0d expected 0,1", qget(got_last, 0), qget(got_last, 1)); end
        total++; if (err_end !== 1'b0) begin bad++; $display("FAIL c1_err: got %b expected 0", err_end); end
        total++; if (rdy_seen != 0 || junk_taken != 0) begin bad++; $display("FAIL c1_no_renorm: in_rdy cycles=%0d chunks taken=%0d expected 0 0", rdy_seen, junk_taken); end
        total++; if (first_lat != 1) begin bad++; $display("FAIL c1_latency: got %0d expected 1", first_lat); end

        chunk_stk.delete(); chunk_stk.push_back(15);
        run_block(78, 2, 100, 100, 0);
        total++; if (qget(got_sym, 0) != 3 || qget(got_sym, 1) != 3 || got_sym.size() != 2) begin bad++; $display("FAIL c2_syms: got %0d,%0d (n=%0d) expected 3,3", qget(got_sym, 0), qget(got_sym, 1), got_sym.size()); end
        total++; if (qget(got_last, 0) != 0 || qget(got_last, 1) != 1) begin bad++; $display("FAIL c2_last: got %0d,%0d expected 0,1", qget(got_last, 0), qget(got_last, 1)); end
        total++; if (chunk_stk.size() != 0 || junk_taken != 0 || rdy_seen == 0) begin bad++; $display("FAIL c2_renorm: left=%0d extra=%0d in_rdy cycles=%0d expected 0 0 >0", chunk_stk.size(), junk_taken, rdy_seen); end
        total++; if (err_end !== 1'b0) begin bad++; $display("FAIL c2_err: got %b expected 0", err_end); end
        total++; if (first_lat != 4) begin bad++; $display("FAIL c2_latency: got %0d expected 4", first_lat); end

        chunk_stk.delete();
        run_block(145, 1, 100, 100, 0);
        total++; if (got_sym.size() != 1 || qget(got_sym, 0) != 0 || qget(got_last, 0) != 1) begin bad++; $display("FAIL c3_sym: got n=%0d sym=%0d last=%0d expected 1 0 1", got_sym.size(), qget(got_sym, 0), qget(got_last, 0)); end
        total++; if (err_end !== 1'b1) begin bad++; $display("FAIL c3_err: got %b expected 1", err_end); end
        total++; if (end_lat != last_acc_lat + 1) begin bad++; $display("FAIL c3_idle_next: got %0d expected %0d", end_lat, last_acc_lat + 1); end

        run_block(145, 0, 100, 100, 0);
        total++; if (got_sym.size() != 1 || qget(got_last, 0) != 1 || err_end !== 1'b1) begin bad++; $display("FAIL nsym0_as_1: got n=%0d last=%0d err=%b expected 1 1 1", got_sym.size(), qget(got_last, 0), err_end); end
    endtask

    task automatic test_stall();
        chunk_stk.delete();
        run_block(145, 2, -1, 0, 1);
        total++; if (qget(got_sym, 0) != 0 || qget(got_sym, 1) != 1 || got_sym.size() != 2) begin bad++; $display("FAIL stall_syms: got %0d,%0d (n=%0d) expected 0,1", qget(got_sym, 0), qget(got_sym, 1), got_sym.size()); end
        total++; if (qget(got_last, 1) != 1 || err_end !== 1'b0) begin bad++; $display("FAIL stall_last_err: got last=%0d err=%b expected 1 0", qget(got_last, 1), err_end); end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_out_stable: got %0d changes expected 0", unstable); end
        run_block(145, 2, 100, 100, 0);
        total++; if (qget(got_sym, 0) != 0 || qget(got_sym, 1) != 1 || err_end !== 1'b0) begin bad++; $display("FAIL stall_tbl_kept_c1: got %0d,%0d err=%b expected 0,1 0", qget(got_sym, 0), qget(got_sym, 1), err_end); end
        chunk_stk.delete(); chunk_stk.push_back(15);
        run_block(78, 2, 100, 100, 0);
        total++; if (qget(got_sym, 0) != 3 || qget(got_sym, 1) != 3 || err_end !== 1'b0) begin bad++; $display("FAIL stall_tbl_kept_c2: got %0d,%0d err=%b expected 3,3 0", qget(got_sym, 0), qget(got_sym, 1), err_end); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 20; b++) begin
            int k, placed, rest, n, p, st;
            bit full;
            int seq [$];
            for (int e = 0; e < NS; e++) tcnt[e] = 0;
            k = $urandom_range(2, 8);
            placed = 0;
            while (placed < k) begin
                p = $urandom_range(0, NS - 1);
                if (tcnt[p] == 0) begin tcnt[p] = 2; placed++; end
            end
            rest = MT - 2 * k;
            while (rest > 0) begin
                p = $urandom_range(0, NS - 1);
                if (tcnt[p] != 0) begin tcnt[p]++; rest--; end
            end
            load_table();
            n = $urandom_range(1, 12);
            seq.delete();
            while (seq.size() < n) begin
                p = $urandom_range(0, NS - 1);
                if (tcnt[p] != 0) seq.push_back(p);
            end
            st = encode(seq);
            full = (b % 4 == 0);
            run_block(st, n, full ? 100 : 75, full ? 100 : 60, 0);
            total++; if (got_sym.size() != n || timed_out != 0) begin bad++; $display("FAIL rand%0d_count: got %0d symbols timeout=%0d expected %0d", b, got_sym.size(), timed_out, n); end
            for (int j = 0; j < n; j++) begin
                total++;
                if (qget(got_sym, j) != seq[n-1-j] || qget(got_last, j) != int'(j == n - 1)) begin
                    bad++; $display("FAIL rand%0d_sym%0d: got sym=%0d last=%0d expected sym=%0d last=%0d", b, j, qget(got_sym, j), qget(got_last, j), seq[n-1-j], int'(j == n - 1));
                end
            end
            total++; if (err_end !== 1'b0) begin bad++; $display("FAIL rand%0d_err: got %b expected 0", b, err_end); end
            total++; if (chunk_stk.size() != 0 || junk_taken != 0) begin bad++; $display("FAIL rand%0d_chunks: left=%0d extra=%0d expected 0 0", b, chunk_stk.size(), junk_taken); end
            total++; if (unstable != 0) begin bad++; $display("FAIL rand%0d_stable: got %0d changes expected 0", b, unstable); end
            if (full) begin
                total++; if (first_lat != seq[n-1] + 1) begin bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", b, first_lat, seq[n-1] + 1); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int w = 0, seen = 0;
        set_case_table();
        load_table();
        chunk_stk.delete(); chunk_stk.push_back(15);
        @(negedge clk);
        ena = 1'b1; bus.init_state = 16'd78; bus.init_nsym = 16'd2;
        bus.init_vld = 1'b1; bus.out_rdy = 1'b1; bus.in_vld = 1'b0;
        @(negedge clk);
        bus.init_vld = 1'b0;
        while (!bus.in_rdy && w < 50) begin @(negedge clk); w++; end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL rmid_reach_renorm: in_rdy=%b expected 1", bus.in_rdy); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.init_rdy !== 1'b1 || bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0) begin bad++; $display("FAIL rmid_handshake: init_rdy=%b in_rdy=%b out_vld=%b expected 1 0 0", bus.init_rdy, bus.in_rdy, bus.out_vld); end
        total++; if (bus.out_sym !== 4'd0 || bus.out_last !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_outputs: out_sym=%0d out_last=%b err=%b expected 0 0 0", bus.out_sym, bus.out_last, err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.in_vld = 1'b1; bus.in_chunk = 4'd15;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_vld || bus.in_rdy) seen++;
        end
        bus.in_vld = 1'b0;
        total++; if (seen != 0) begin bad++; $display("FAIL rmid_no_partial: got %0d active cycles expected 0", seen); end
        load_table();
        chunk_stk.delete();
        run_block(145, 2, 100, 100, 0);
        total++; if (qget(got_sym, 0) != 0 || qget(got_sym, 1) != 1 || got_sym.size() != 2 || err_end !== 1'b0) begin bad++; $display("FAIL rmid_fresh_c1: got %0d,%0d (n=%0d) err=%b expected 0,1 0", qget(got_sym, 0), qget(got_sym, 1), got_sym.size(), err_end); end
    endtask

    initial begin
        bus.init_vld = 1'b0; bus.init_state = '0; bus.init_nsym = '0;
        bus.in_vld = 1'b0; bus.in_chunk = '0; bus.out_rdy = 1'b0;
        test_reset();
        test_zero_table();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
